reg_bank_snap: RTL and testbench
================================

REG_BANK_SNAP -- requirements
Module: reg_bank_snap

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data bits per channel (legal range 1..64).
REQ-002 The block SHALL have parameter CHANNELS, default 4, giving the number of independent storage channels (legal range 1..32).
REQ-003 The block SHALL have derived parameter SELW = max(1, clog2(CHANNELS)).
REQ-004 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port d, input, CHANNELS*WIDTH bits: channel i data at d[i*WIDTH +: WIDTH].
REQ-007 The block SHALL have port en, input, CHANNELS bits: per-channel load enable.
REQ-008 The block SHALL have port sclr, input, CHANNELS bits: per-channel synchronous clear.
REQ-009 The block SHALL have port q, output, CHANNELS*WIDTH bits: live channel values.
REQ-010 The block SHALL have port chg, output, CHANNELS bits: per-channel value-changed pulse.
REQ-011 The block SHALL have port snap, input, 1 bit: copy all live values into the shadow bank.
REQ-012 The block SHALL have port rd_req, input, 1 bit: shadow read request.
REQ-013 The block SHALL have port rd_sel, input, SELW bits: channel index for the read.
REQ-014 The block SHALL have port rd_valid, output, 1 bit: read data available.
REQ-015 The block SHALL have port rd_ready, input, 1 bit: consumer accepts read data.
REQ-016 The block SHALL have port rd_data, output, WIDTH bits: shadow value of the selected channel.
REQ-017 The block SHALL have port rd_err, output, 1 bit: qualifies rd_data; set when rd_sel >= CHANNELS.

Function
REQ-018 Live channel i SHALL update on the rising clk edge only (edge-triggered, never transparent), with priority sclr[i] (q_i <= 0) > en[i] (q_i <= d_i) > hold.
REQ-019 Each channel SHALL be independent; any combination of en/sclr bits in one cycle SHALL be honoured per channel.
REQ-020 chg[i] SHALL be 1 for exactly the cycle after an edge at which q_i took a new value differing from its old value, and 0 otherwise (loading an equal value gives chg[i]=0).
REQ-021 On a snap=1 edge, all CHANNELS shadow entries SHALL capture the pre-edge q values atomically, so a simultaneous en/sclr is not visible in the shadow until the next snap.
REQ-022 The read port SHALL be a two-state FSM, IDLE (rd_valid=0) and HOLD (rd_valid=1).
REQ-023 In IDLE, rd_req=1 SHALL register rd_sel and go to HOLD; rd_valid SHALL rise the following cycle (latency 1).
REQ-024 In HOLD, rd_data and rd_err SHALL stay stable until rd_ready=1.
REQ-025 In HOLD, rd_ready=1 with rd_req=0 SHALL return the FSM to IDLE.
REQ-026 In HOLD, rd_ready=1 with rd_req=1 SHALL accept the new request back-to-back and keep rd_valid=1 with the new data next cycle.
REQ-027 rd_req in HOLD without rd_ready SHALL be ignored (not queued).
REQ-028 rd_data SHALL be sampled from the shadow at acceptance: a snap in the same cycle as acceptance returns the pre-snap shadow, and a later snap does not alter held rd_data.
REQ-029 rd_sel >= CHANNELS SHALL give rd_data=0 and rd_err=1 with a normal handshake; otherwise rd_err=0.
REQ-030 CHANNELS=1 SHALL ignore rd_sel (index 0 always) and SHALL never assert rd_err.

Reset
REQ-031 rst_n=0 SHALL immediately, independent of clk, force q=0, shadow=0, chg=0, rd_valid=0, rd_data=0, rd_err=0 and the FSM to IDLE.
REQ-032 A read in progress at reset SHALL be discarded.
REQ-033 The first edge after rst_n rises SHALL be a normal functional edge.
REQ-034 No output SHALL be X after reset.

Verification
REQ-035 Defaults, en=4'b0101, d={8'h44,8'h33,8'h22,8'h11} -> q ch0=8'h11, ch2=8'h33, ch1/ch3=0; chg=4'b0101 for one cycle.
REQ-036 ch0=8'h11, en[0]=1 and sclr[0]=1 together -> q ch0=0, chg[0]=1; repeat with d=8'h00 and en only -> chg[0]=0.
REQ-037 q ch1=8'hA5, snap=1 with en[1]=1 and d ch1=8'h5A on the same edge -> shadow ch1=8'hA5; rd_sel=1 read -> rd_data=8'hA5 after one cycle.
REQ-038 rd_valid held with rd_ready=0 for 5 cycles while snap toggles -> rd_data constant; rd_ready=1 with rd_req=1, rd_sel=2 -> rd_valid stays 1 and rd_data = shadow ch2.
REQ-039 CHANNELS=3, rd_sel=3 -> rd_valid=1, rd_err=1, rd_data=0.
REQ-040 rst_n pulsed low between clk edges while rd_valid=1 and q nonzero -> outputs zero at once, not at the next edge.

Source files
------------

// File: rtl/reg_bank_snap.sv
// reg_bank_snap: per-channel registers with change pulses, an atomic shadow snapshot
// and a ready/valid read port into the shadow bank.
module reg_bank_snap #(
  parameter int WIDTH = 8,
  parameter int CHANNELS = 4,
  parameter int SELW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] d,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS-1:0]       sclr,
  output logic [CHANNELS*WIDTH-1:0] q,
  output logic [CHANNELS-1:0]       chg,
  input  logic                      snap,
  input  logic                      rd_req,
  input  logic [SELW-1:0]           rd_sel,
  output logic                      rd_valid,
  input  logic                      rd_ready,
  output logic [WIDTH-1:0]          rd_data,
  output logic                      rd_err
);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t state_q, state_d;
  logic [CHANNELS*WIDTH-1:0] q_q, q_d, shadow_q, shadow_d;
  logic [CHANNELS-1:0] chg_q, chg_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d, rd_pick;
  logic rd_err_q, rd_err_d, rd_bad, accept;
  always_comb begin
    q_d = q_q;
    chg_d = '0;
    shadow_d = snap ? q_q : shadow_q;
    rd_pick = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      q_d[i*WIDTH +: WIDTH] = sclr[i] ? '0 : en[i] ? d[i*WIDTH +: WIDTH] : q_q[i*WIDTH +: WIDTH];
      chg_d[i] = q_d[i*WIDTH +: WIDTH] != q_q[i*WIDTH +: WIDTH];
      if (CHANNELS == 1 || 32'(rd_sel) == i) rd_pick = shadow_q[i*WIDTH +: WIDTH];
    end
    // out-of-range selects match no channel, so rd_pick stays zero
    rd_bad = (CHANNELS > 1) && (32'(rd_sel) >= CHANNELS);
    accept = rd_req && (state_q == IDLE || rd_ready);
    state_d = accept ? HOLD : rd_ready ? IDLE : state_q;
    rd_data_d = accept ? rd_pick : rd_data_q;
    rd_err_d = accept ? rd_bad : rd_err_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
      chg_q <= '0;
      shadow_q <= '0;
      state_q <= IDLE;
      rd_data_q <= '0;
      rd_err_q <= 1'b0;
    end else begin
      q_q <= q_d;
      chg_q <= chg_d;
      shadow_q <= shadow_d;
      state_q <= state_d;
      rd_data_q <= rd_data_d;
      rd_err_q <= rd_err_d;
    end
  end
  assign q = q_q;
  assign chg = chg_q;
  assign rd_valid = state_q == HOLD;
  assign rd_data = rd_data_q;
  assign rd_err = rd_err_q;
endmodule

// File: tb/tb_reg_bank_snap.sv
// tb_reg_bank_snap: directed bench for reg_bank_snap (default instance plus a 3-channel instance),
// read results checked through an expected-value queue.
module tb_reg_bank_snap;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [31:0] d = '0;
  logic [3:0] en = '0, sclr = '0;
  logic [31:0] q;
  logic [3:0] chg;
  logic snap = 1'b0, rd_req = 1'b0, rd_ready = 1'b0;
  logic [1:0] rd_sel = '0;
  logic rd_valid, rd_err;
  logic [7:0] rd_data;
  logic [23:0] d3 = '0, q3;
  logic [2:0] en3 = '0, sclr3 = '0, chg3;
  logic snap3 = 1'b0, rd_req3 = 1'b0, rd_ready3 = 1'b0;
  logic [1:0] rd_sel3 = '0;
  logic rd_valid3, rd_err3;
  logic [7:0] rd_data3;
  int tests = 0, fails = 0;
  logic [8:0] sb[$];
  logic [8:0] exp_rd;

  always #5 clk = ~clk;

  reg_bank_snap dut (.clk(clk), .rst_n(rst_n), .d(d), .en(en), .sclr(sclr), .q(q), .chg(chg),
    .snap(snap), .rd_req(rd_req), .rd_sel(rd_sel), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_err(rd_err));

  reg_bank_snap #(.WIDTH(8), .CHANNELS(3)) dut3 (.clk(clk), .rst_n(rst_n), .d(d3), .en(en3),
    .sclr(sclr3), .q(q3), .chg(chg3), .snap(snap3), .rd_req(rd_req3), .rd_sel(rd_sel3),
    .rd_valid(rd_valid3), .rd_ready(rd_ready3), .rd_data(rd_data3), .rd_err(rd_err3));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pop_chk(input string tag, input logic v, input logic e, input logic [7:0] dat);
    chk({tag, "_valid"}, 64'(v), 64'(1));
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'(0), 64'(1));
    end else begin
      exp_rd = sb.pop_front();
      chk({tag, "_data"}, 64'({e, dat}), 64'(exp_rd));
    end
  endtask

  initial begin
    #2;
    chk("rst_q", 64'(q), 64'(0));
    chk("rst_outs", 64'({chg, rd_valid, rd_err, rd_data}), 64'(0));
    chk("rst_q3", 64'({q3, chg3, rd_valid3, rd_err3, rd_data3}), 64'(0));
    tick();
    rst_n = 1'b1;
    d = 32'h44332211;
    en = 4'b0101;
    tick();
    en = '0;
    chk("load_q", 64'(q), 64'h0033_0011);
    chk("load_chg", 64'(chg), 64'(4'b0101));
    tick();
    chk("chg_once", 64'(chg), 64'(0));
    en = 4'b0001;
    sclr = 4'b0001;
    tick();
    chk("sclr_q", 64'(q), 64'h0033_0000);
    chk("sclr_chg", 64'(chg), 64'(4'b0001));
    sclr = '0;
    d = 32'h0;
    tick();
    en = '0;
    chk("same_chg", 64'(chg), 64'(0));
    d = 32'h0000_A500;
    en = 4'b0010;
    tick();
    chk("ld_a5", 64'(q), 64'h0033_A500);
    d = 32'h0000_5A00;
    snap = 1'b1;
    tick();
    snap = 1'b0;
    en = '0;
    chk("snap_live", 64'(q), 64'h0033_5A00);
    rd_req = 1'b1;
    rd_sel = 2'd1;
    sb.push_back({1'b0, 8'hA5});
    tick();
    rd_req = 1'b0;
    pop_chk("rd_ch1", rd_valid, rd_err, rd_data);
    for (int i = 0; i < 5; i++) begin
      snap = i[0];
      rd_req = 1'b1;
      rd_sel = 2'd0;
      tick();
      chk("hold_valid", 64'(rd_valid), 64'(1));
      chk("hold_data", 64'(rd_data), 64'hA5);
    end
    snap = 1'b0;
    rd_ready = 1'b1;
    rd_sel = 2'd2;
    sb.push_back({1'b0, 8'h33});
    tick();
    rd_req = 1'b0;
    pop_chk("b2b_ch2", rd_valid, rd_err, rd_data);
    tick();
    chk("idle_valid", 64'(rd_valid), 64'(0));
    rd_ready = 1'b0;
    d = 32'h0000_0099;
    en = 4'b0001;
    tick();
    en = '0;
    rd_req = 1'b1;
    rd_sel = 2'd0;
    snap = 1'b1;
    sb.push_back({1'b0, 8'h00});
    tick();
    rd_req = 1'b0;
    snap = 1'b0;
    pop_chk("rd_presnap", rd_valid, rd_err, rd_data);
    rd_ready = 1'b1;
    rd_req = 1'b1;
    sb.push_back({1'b0, 8'h99});
    tick();
    rd_req = 1'b0;
    rd_ready = 1'b0;
    pop_chk("rd_postsnap", rd_valid, rd_err, rd_data);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_q", 64'(q), 64'(0));
    chk("arst_outs", 64'({chg, rd_valid, rd_err, rd_data}), 64'(0));
    tick();
    chk("arst_hold", 64'({q, rd_valid}), 64'(0));
    rst_n = 1'b1;
    d = 32'h0000_0007;
    en = 4'b0001;
    tick();
    en = '0;
    chk("post_rst_q", 64'(q), 64'h7);
    chk("post_rst_rd", 64'(rd_valid), 64'(0));
    d3 = 24'hC3_0000;
    en3 = 3'b100;
    tick();
    en3 = '0;
    snap3 = 1'b1;
    tick();
    snap3 = 1'b0;
    rd_req3 = 1'b1;
    rd_sel3 = 2'd2;
    sb.push_back({1'b0, 8'hC3});
    tick();
    pop_chk("c3_ch2", rd_valid3, rd_err3, rd_data3);
    rd_ready3 = 1'b1;
    rd_sel3 = 2'd3;
    sb.push_back({1'b1, 8'h00});
    tick();
    rd_req3 = 1'b0;
    pop_chk("c3_sel3", rd_valid3, rd_err3, rd_data3);
    tick();
    chk("c3_idle", 64'(rd_valid3), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
